memory_layer_recall_controller: RTL and testbench

- Read-side counterpart of the memory layer learning controller; active when learning_recall==RECALL.
- Accepts one input vector X and scans the stored node memory (weight vector W, class C) over addresses 0..node_count-1.
- Finds the node at minimum Manhattan distance and returns its class and distance through a held result handshake.
- Sits beside the learning controller on the same node memories; it only ever issues READs.

---
 rtl/memory_layer_recall_controller_pkg.sv | 10 +
 rtl/memory_layer_recall_controller_manhattan_distance.sv | 24 ++
 rtl/memory_layer_recall_controller.sv | 130 +++++++++++++
 tb/tb_memory_layer_recall_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/memory_layer_recall_controller_pkg.sv
// memory_layer_recall_controller_pkg: shared handshake/mode enums, recall FSM states and distance width helper.
package memory_layer_recall_controller_pkg;
  typedef enum logic {WAIT = 1'b0, READY = 1'b1} READY_WAIT_T;
  typedef enum logic {LEARNING = 1'b0, RECALL = 1'b1} LEARNING_RECALL_T;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} RD_WR_T;
  typedef enum logic [2:0] {S_IDLE, S_READY, S_SCAN, S_DRAIN, S_DONE} RECALL_STATE_T;
  function automatic int dist_width(input int dim, input int data_w);
    return data_w + $clog2(dim) + 1;
  endfunction
endpackage

// File: rtl/memory_layer_recall_controller_manhattan_distance.sv
// memory_layer_recall_controller_manhattan_distance: combinational sum of |x_i - w_i| over DIM elements.
module memory_layer_recall_controller_manhattan_distance
  import memory_layer_recall_controller_pkg::*;
#(
  parameter int DIM = 4,
  parameter int DATA_W = 8,
  localparam int DIST_W = dist_width(DIM, DATA_W)
) (
  input  logic [DIM*DATA_W-1:0] x_i,
  input  logic [DIM*DATA_W-1:0] w_i,
  output logic [DIST_W-1:0]     dist_o
);
  logic [DIM-1:0][DATA_W-1:0] ad;
  genvar g;
  for (g = 0; g < DIM; g++) begin : g_abs
    assign ad[g] = x_i[g*DATA_W +: DATA_W] > w_i[g*DATA_W +: DATA_W]
                 ? x_i[g*DATA_W +: DATA_W] - w_i[g*DATA_W +: DATA_W]
                 : w_i[g*DATA_W +: DATA_W] - x_i[g*DATA_W +: DATA_W];
  end
  always_comb begin
    dist_o = '0;
    for (int i = 0; i < DIM; i++) dist_o = dist_o + DIST_W'(ad[i]);
  end
endmodule

// File: rtl/memory_layer_recall_controller.sv
// memory_layer_recall_controller: scans stored nodes with READs only and returns the nearest node
// (Manhattan distance, lowest address on ties) through a held result handshake.
module memory_layer_recall_controller
  import memory_layer_recall_controller_pkg::*;
#(
  parameter int DIM = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int CLASS_W = 4,
  localparam int DIST_W = dist_width(DIM, DATA_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  LEARNING_RECALL_T      learning_recall,
  input  logic [ADDR_W:0]       node_count,
  input  logic [DIM*DATA_W-1:0] x_in,
  input  logic                  x_valid,
  output READY_WAIT_T           ready_wait,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  output RD_WR_T                RD_WR_c,
  input  logic [DIM*DATA_W-1:0] w_rd_data,
  input  logic [CLASS_W-1:0]    c_rd_data,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic [CLASS_W-1:0]    class_out,
  output logic [DIST_W-1:0]     dist_out,
  output logic [ADDR_W-1:0]     win_addr,
  output logic                  no_node
);
  localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
  RECALL_STATE_T         state_q;
  READY_WAIT_T           rw_q;
  logic [DIM*DATA_W-1:0] x_q;
  logic [ADDR_W:0]       cnt_q, idx_q, cnt_in;
  logic                  pend_q, rd_en_q, rv_q, nn_q, upd;
  logic [ADDR_W-1:0]     pend_addr_q, addr_q, min_addr_q, min_addr_d, win_q;
  logic [DIST_W-1:0]     d, min_dist_q, min_dist_d, dist_q;
  logic [CLASS_W-1:0]    min_cls_q, min_cls_d, cls_q;
  memory_layer_recall_controller_manhattan_distance #(.DIM(DIM), .DATA_W(DATA_W)) u_dist (
    .x_i(x_q), .w_i(w_rd_data), .dist_o(d)
  );
  // Read data lags the strobe by one cycle, so the compare tracks the strobe through pend_q.
  assign upd        = pend_q && (d < min_dist_q);
  assign min_dist_d = upd ? d : min_dist_q;
  assign min_cls_d  = upd ? c_rd_data : min_cls_q;
  assign min_addr_d = upd ? pend_addr_q : min_addr_q;
  assign cnt_in     = node_count > MAX_N ? MAX_N : node_count;
  assign ready_wait   = rw_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_addr     = addr_q;
  assign RD_WR_c      = READ;
  assign result_valid = rv_q;
  assign class_out    = cls_q;
  assign dist_out     = dist_q;
  assign win_addr     = win_q;
  assign no_node      = nn_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rw_q <= WAIT;
      x_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      pend_q <= 1'b0;
      pend_addr_q <= '0;
      rd_en_q <= 1'b0;
      addr_q <= '0;
      min_dist_q <= '0;
      min_cls_q <= '0;
      min_addr_q <= '0;
      rv_q <= 1'b0;
      cls_q <= '0;
      dist_q <= '0;
      win_q <= '0;
      nn_q <= 1'b0;
    end else begin
      pend_q <= rd_en_q;
      pend_addr_q <= addr_q;
      min_dist_q <= min_dist_d;
      min_cls_q <= min_cls_d;
      min_addr_q <= min_addr_d;
      case (state_q)
        S_IDLE: if (learning_recall == RECALL) begin
          state_q <= S_READY;
          rw_q <= READY;
        end
        S_READY: if (x_valid) begin
          x_q <= x_in;
          cnt_q <= cnt_in;
          idx_q <= (ADDR_W+1)'(1);
          min_dist_q <= '1;
          nn_q <= 1'b0;
          rw_q <= WAIT;
          if (cnt_in == '0) begin
            state_q <= S_DONE;
            rv_q <= 1'b1;
            nn_q <= 1'b1;
            cls_q <= '0;
            win_q <= '0;
            dist_q <= '1;
          end else begin
            state_q <= S_SCAN;
            rd_en_q <= 1'b1;
            addr_q <= '0;
          end
        end
        S_SCAN: if (idx_q == cnt_q) begin
          rd_en_q <= 1'b0;
          state_q <= S_DRAIN;
        end else begin
          addr_q <= idx_q[ADDR_W-1:0];
          idx_q <= idx_q + (ADDR_W+1)'(1);
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          rv_q <= 1'b1;
          cls_q <= min_cls_d;
          dist_q <= min_dist_d;
          win_q <= min_addr_d;
        end
        S_DONE: if (result_ack) begin
          rv_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_layer_recall_controller.sv
// tb_memory_layer_recall_controller: directed and randomized recalls against a nearest-node reference model.
module tb_memory_layer_recall_controller;
  import memory_layer_recall_controller_pkg::*;
  localparam int DIM = 4, DW = 8, AW = 6, CW = 4, DSW = DW + $clog2(DIM) + 1;
  logic clk = 1'b0, reset = 1'b0;
  LEARNING_RECALL_T learning_recall = LEARNING;
  logic [AW:0] node_count = '0;
  logic [DIM*DW-1:0] x_in = '0, w_rd_data = '0;
  logic x_valid = 1'b0, result_ack = 1'b0;
  logic [CW-1:0] c_rd_data = '0;
  READY_WAIT_T ready_wait;
  RD_WR_T RD_WR_c;
  logic mem_rd_en, result_valid, no_node;
  logic [AW-1:0] mem_addr, win_addr;
  logic [CW-1:0] class_out;
  logic [DSW-1:0] dist_out;
  int n_vec = 0, n_bad = 0;
  logic [DW-1:0] mw[64][DIM];
  logic [CW-1:0] mc[64];
  int xv[DIM];
  int rd_log[$];
  memory_layer_recall_controller dut (
    .clk(clk), .reset(reset), .learning_recall(learning_recall), .node_count(node_count),
    .x_in(x_in), .x_valid(x_valid), .ready_wait(ready_wait), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .RD_WR_c(RD_WR_c), .w_rd_data(w_rd_data), .c_rd_data(c_rd_data),
    .result_valid(result_valid), .result_ack(result_ack), .class_out(class_out),
    .dist_out(dist_out), .win_addr(win_addr), .no_node(no_node)
  );
  always #5 clk = ~clk;
  function automatic logic [DIM*DW-1:0] wpack(int a);
    logic [DIM*DW-1:0] r;
    for (int i = 0; i < DIM; i++) r[i*DW +: DW] = mw[a][i];
    return r;
  endfunction
  always @(posedge clk) begin
    if (mem_rd_en) begin
      w_rd_data <= wpack(int'(mem_addr));
      c_rd_data <= mc[mem_addr];
      rd_log.push_back(int'(mem_addr));
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int mdist(int a);
    int s = 0;
    for (int i = 0; i < DIM; i++) s += (xv[i] > int'(mw[a][i])) ? xv[i] - int'(mw[a][i]) : int'(mw[a][i]) - xv[i];
    return s;
  endfunction
  task automatic do_recall(input string tg, input int n, input int hold, input LEARNING_RECALL_T after);
    int t, lat, ne, best, bd, seq_ok, stable;
    logic [31:0] snap;
    logic [DIM*DW-1:0] xp;
    learning_recall = RECALL;
    t = 0;
    while (ready_wait !== READY && t < 20) begin @(posedge clk); #1; t++; end
    chk({tg, "_ready"}, 32'(ready_wait), 32'(READY));
    for (int i = 0; i < DIM; i++) xp[i*DW +: DW] = DW'(xv[i]);
    x_in = xp;
    node_count = (AW+1)'(n);
    x_valid = 1'b1;
    rd_log.delete();
    @(posedge clk); #1;
    x_valid = 1'b0;
    lat = 1;
    while (result_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    ne = n > 64 ? 64 : n;
    chk({tg, "_latency"}, lat, ne == 0 ? 1 : ne + 2);
    if (ne == 0) begin
      chk({tg, "_no_node"}, 32'(no_node), 1);
      chk({tg, "_class"}, 32'(class_out), 0);
      chk({tg, "_win"}, 32'(win_addr), 0);
      chk({tg, "_dist"}, 32'(dist_out), (1 << DSW) - 1);
    end else begin
      best = 0;
      bd = mdist(0);
      for (int a = 1; a < ne; a++) if (mdist(a) < bd) begin bd = mdist(a); best = a; end
      chk({tg, "_no_node"}, 32'(no_node), 0);
      chk({tg, "_class"}, 32'(class_out), 32'(mc[best]));
      chk({tg, "_win"}, 32'(win_addr), best);
      chk({tg, "_dist"}, 32'(dist_out), bd);
    end
    chk({tg, "_reads"}, rd_log.size(), ne);
    seq_ok = 1;
    foreach (rd_log[k]) if (rd_log[k] != k) seq_ok = 0;
    chk({tg, "_read_order"}, seq_ok, 1);
    snap = {9'd0, class_out, dist_out, win_addr, no_node, result_valid};
    stable = 1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if ({9'd0, class_out, dist_out, win_addr, no_node, result_valid} !== snap) stable = 0;
    end
    if (hold > 0) chk({tg, "_hold"}, stable, 1);
    learning_recall = after;
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    chk({tg, "_ack_drop"}, 32'(result_valid), 0);
  endtask
  initial begin
    int cnt;
    for (int a = 0; a < 64; a++) begin
      mc[a] = '0;
      for (int i = 0; i < DIM; i++) mw[a][i] = '0;
    end
    #1;
    chk("rst_rv", 32'(result_valid), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_ready_wait", 32'(ready_wait), 32'(WAIT));
    chk("rst_outs", {9'd0, class_out, dist_out, win_addr, no_node, mem_addr}, 0);
    chk("rst_rdwr", 32'(RD_WR_c), 32'(READ));
    #16 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < DIM; i++) begin mw[0][i] = 8'd10; mw[1][i] = 8'd50; end
    mc[0] = 4'd3; mc[1] = 4'd7;
    xv = '{12, 9, 10, 11};
    do_recall("basic", 2, 0, RECALL);
    chk("basic_class_const", 32'(class_out), 3);
    chk("basic_dist_const", 32'(dist_out), 4);
    for (int i = 0; i < DIM; i++) mw[2][i] = 8'd10;
    mc[2] = 4'd5;
    do_recall("tie", 3, 0, RECALL);
    chk("tie_win_const", 32'(win_addr), 0);
    do_recall("empty", 0, 0, LEARNING);
    rd_log.delete();
    x_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (ready_wait !== WAIT) cnt++;
    end
    x_valid = 1'b0;
    chk("gate_wait", cnt, 0);
    chk("gate_reads", rd_log.size(), 0);
    learning_recall = RECALL;
    @(posedge clk); #1;
    chk("gate_ready", 32'(ready_wait), 32'(READY));
    xv = '{255, 255, 255, 255};
    for (int i = 0; i < DIM; i++) mw[0][i] = 8'd0;
    do_recall("maxdist", 1, 10, RECALL);
    chk("maxdist_const", 32'(dist_out), 1020);
    for (int a = 0; a < 8; a++) begin
      mc[a] = CW'($urandom);
      for (int i = 0; i < DIM; i++) mw[a][i] = DW'($urandom);
    end
    xv = '{1, 2, 3, 4};
    cnt = 0;
    while (ready_wait !== READY && cnt < 20) begin @(posedge clk); #1; cnt++; end
    node_count = 7'd8;
    x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_rd_en", 32'(mem_rd_en), 0);
    chk("rst_mid_rv", 32'(result_valid), 0);
    chk("rst_mid_wait", 32'(ready_wait), 32'(WAIT));
    @(posedge clk); #3 reset = 1'b1;
    do_recall("after_rst", 8, 0, RECALL);
    for (int tr = 0; tr < 30; tr++) begin
      int n;
      for (int a = 0; a < 64; a++) begin
        mc[a] = CW'($urandom);
        for (int i = 0; i < DIM; i++) mw[a][i] = DW'($urandom_range(0, 3) * 40);
      end
      for (int i = 0; i < DIM; i++) xv[i] = $urandom_range(0, 255);
      n = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 12);
      do_recall($sformatf("rand%0d", tr), n, $urandom_range(0, 3), RECALL);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
